// File: rtl/qpu_ifu_ifetch.sv
// Instruction fetch unit: one-outstanding memory read, IR plus one skid entry, flush and halt control.
// Define QPU_IFU_STATIC_BPU_EN to enable static backward-taken branch prediction on fetched branches.
`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_INSTR_SIZE
`define QPU_INSTR_SIZE 32
`endif
`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif

module qpu_ifu_ifetch #(
  parameter logic [`QPU_PC_SIZE-1:0] RESET_PC = `QPU_PC_SIZE'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ifu_req_en,
  output logic [`QPU_PC_SIZE-1:0]    ifu_req_addr,
  input  logic [`QPU_INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                       ifu_o_valid,
  input  logic                       exu_i_ready,
  output logic [`QPU_INSTR_SIZE-1:0] ifu_o_ir,
  output logic [`QPU_PC_SIZE-1:0]    ifu_o_pc,
  output logic                       ifu_o_prdt_taken,
  input  logic                       exu_flush_req,
  input  logic [`QPU_PC_SIZE-1:0]    exu_flush_pc,
  input  logic                       exu_halt_req,
  output logic                       ifu_halt_ack
);

  localparam int unsigned PC_W = `QPU_PC_SIZE;
  localparam int unsigned IW   = `QPU_INSTR_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic            out_q;
  logic            ir_valid_q, sk_valid_q;
  logic [IW-1:0]   ir_instr_q, sk_instr_q;
  logic [PC_W-1:0] ir_pc_q, sk_pc_q;
  logic            ir_taken_q, sk_taken_q;

  logic            rsp_v;
  logic            ir_free;
  logic            handoff;
  logic [1:0]      occ;
  logic            fetch_room;
  logic            rsp_taken;
  logic            redirect;
  logic [PC_W-1:0] bpu_target;
  logic [PC_W-1:0] fetch_pc;

  // The response of the outstanding read lands this cycle unless a flush discards it.
  assign rsp_v      = out_q && !exu_flush_req;
  assign handoff    = ir_valid_q && exu_i_ready;
  assign ir_free    = !ir_valid_q || exu_i_ready;
  assign occ        = 2'(ir_valid_q) + 2'(sk_valid_q) + 2'(out_q);
  assign fetch_room = handoff ? (occ <= 2'd2) : (occ <= 2'd1);

`ifdef QPU_IFU_STATIC_BPU_EN
  localparam int unsigned XLEN = `QPU_XLEN;

  logic [PC_W-1:0] out_pc_q;
  logic            rsp_is_br;
  logic [XLEN-1:0] rsp_imm;

  assign rsp_is_br  = ifu_rsp_instr[6:0] == 7'b1100011;
  assign rsp_imm    = {{(XLEN-13){ifu_rsp_instr[31]}}, ifu_rsp_instr[31], ifu_rsp_instr[7],
                       ifu_rsp_instr[30:25], ifu_rsp_instr[11:8], 1'b0};
  assign rsp_taken  = rsp_is_br && rsp_imm[XLEN-1];
  assign bpu_target = out_pc_q + PC_W'($signed(rsp_imm));
  assign redirect   = rsp_v && rsp_taken;

  // Address of the read in flight, needed to form the branch target.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pc_q <= '0;
    end else if (ifu_req_en) begin
      out_pc_q <= ifu_req_addr;
    end
  end
`else
  assign rsp_taken  = 1'b0;
  assign redirect   = 1'b0;
  assign bpu_target = pc_q;
`endif

  assign fetch_pc = redirect ? bpu_target : pc_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush wins; no request is issued while halting, so HALT follows with nothing in flight.
  always_comb begin
    state_d = state_q;
    if (exu_flush_req) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: if (exu_halt_req) state_d = S_HALT;
        S_HALT:  if (!exu_halt_req) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Request and acknowledge outputs.
  always_comb begin
    ifu_req_en   = 1'b0;
    ifu_req_addr = fetch_pc;
    ifu_halt_ack = 1'b0;
    case (state_q)
      S_FETCH: ifu_req_en = !exu_flush_req && !exu_halt_req && fetch_room;
      S_HALT:  ifu_halt_ack = 1'b1;
      default: ;
    endcase
  end

  // Fetch PC, outstanding flag and the IR/skid queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      out_q      <= 1'b0;
      ir_valid_q <= 1'b0;
      ir_instr_q <= '0;
      ir_pc_q    <= '0;
      ir_taken_q <= 1'b0;
      sk_valid_q <= 1'b0;
      sk_instr_q <= '0;
      sk_pc_q    <= '0;
      sk_taken_q <= 1'b0;
    end else if (exu_flush_req) begin
      pc_q       <= exu_flush_pc;
      out_q      <= 1'b0;
      ir_valid_q <= 1'b0;
      sk_valid_q <= 1'b0;
    end else begin
      out_q <= ifu_req_en;
      if (ifu_req_en) begin
        pc_q <= ifu_req_addr + PC_W'(4);
      end else if (redirect) begin
        pc_q <= bpu_target;
      end

      if (ir_free) begin
        if (sk_valid_q) begin
          ir_instr_q <= sk_instr_q;
          ir_pc_q    <= sk_pc_q;
          ir_taken_q <= sk_taken_q;
          sk_valid_q <= rsp_v;
          if (rsp_v) begin
            sk_instr_q <= ifu_rsp_instr;
            sk_pc_q    <= pc_q - PC_W'(4);
            sk_taken_q <= rsp_taken;
          end
        end else if (rsp_v) begin
          ir_valid_q <= 1'b1;
          ir_instr_q <= ifu_rsp_instr;
          ir_pc_q    <= pc_q - PC_W'(4);
          ir_taken_q <= rsp_taken;
        end else begin
          ir_valid_q <= 1'b0;
        end
      end else if (rsp_v) begin
        sk_valid_q <= 1'b1;
        sk_instr_q <= ifu_rsp_instr;
        sk_pc_q    <= pc_q - PC_W'(4);
        sk_taken_q <= rsp_taken;
      end
    end
  end

  assign ifu_o_valid      = ir_valid_q;
  assign ifu_o_ir         = ir_instr_q;
  assign ifu_o_pc         = ir_pc_q;
  assign ifu_o_prdt_taken = ir_taken_q;

endmodule

// File: tb/tb_qpu_ifu_ifetch.sv
// Directed bench for qpu_ifu_ifetch: cycle table from reset plus reset/branch-prediction sequences.
`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_INSTR_SIZE
`define QPU_INSTR_SIZE 32
`endif

module tb_qpu_ifu_ifetch;

  logic                       clk;
  logic                       rst;
  logic                       ifu_req_en;
  logic [`QPU_PC_SIZE-1:0]    ifu_req_addr;
  logic [`QPU_INSTR_SIZE-1:0] ifu_rsp_instr;
  logic                       ifu_o_valid;
  logic                       exu_i_ready;
  logic [`QPU_INSTR_SIZE-1:0] ifu_o_ir;
  logic [`QPU_PC_SIZE-1:0]    ifu_o_pc;
  logic                       ifu_o_prdt_taken;
  logic                       exu_flush_req;
  logic [`QPU_PC_SIZE-1:0]    exu_flush_pc;
  logic                       exu_halt_req;
  logic                       ifu_halt_ack;

  int checks;
  int errors;
  logic [31:0] br_word;

  qpu_ifu_ifetch dut (
    .clk              (clk),
    .rst              (rst),
    .ifu_req_en       (ifu_req_en),
    .ifu_req_addr     (ifu_req_addr),
    .ifu_rsp_instr    (ifu_rsp_instr),
    .ifu_o_valid      (ifu_o_valid),
    .exu_i_ready      (exu_i_ready),
    .ifu_o_ir         (ifu_o_ir),
    .ifu_o_pc         (ifu_o_pc),
    .ifu_o_prdt_taken (ifu_o_prdt_taken),
    .exu_flush_req    (exu_flush_req),
    .exu_flush_pc     (exu_flush_pc),
    .exu_halt_req     (exu_halt_req),
    .ifu_halt_ack     (ifu_halt_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a non-branch word tagged with its address, except a patchable word at 0x20.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h20) return br_word;
    return {a[24:0], 7'h13};
  endfunction

  // One-cycle read latency memory.
  always @(posedge clk) begin
    if (ifu_req_en) ifu_rsp_instr <= word(ifu_req_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        fl;
    logic [31:0] fpc;
    logic        hlt;
    logic        req;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] opc;
    logic        ack;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rdy, input logic fl, input logic [31:0] fpc, input logic hlt,
                              input logic req, input logic [31:0] addr, input logic ov,
                              input logic [31:0] opc, input logic ack);
    vec_t v;
    v.rdy = rdy; v.fl = fl; v.fpc = fpc; v.hlt = hlt;
    v.req = req; v.addr = addr; v.ov = ov; v.opc = opc; v.ack = ack;
    return v;
  endfunction

  task automatic drive(input logic rdy, input logic fl, input logic [31:0] fpc, input logic hlt);
    @(negedge clk);
    exu_i_ready   = rdy;
    exu_flush_req = fl;
    exu_flush_pc  = fpc;
    exu_halt_req  = hlt;
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_en", 32'(ifu_req_en), 32'd0);
    chk("rst_o_valid", 32'(ifu_o_valid), 32'd0);
    chk("rst_halt_ack", 32'(ifu_halt_ack), 32'd0);
    chk("rst_o_ir", 32'(ifu_o_ir), 32'd0);
    chk("rst_o_pc", 32'(ifu_o_pc), 32'd0);
    chk("rst_o_taken", 32'(ifu_o_prdt_taken), 32'd0);
  endtask

  logic [31:0] exp_next;
  logic [31:0] exp_after;
  logic        exp_taken;

  initial begin
    checks = 0;
    errors = 0;
    br_word = {25'h20, 7'h13};
    rst = 1'b1;
    exu_i_ready = 1'b0;
    exu_flush_req = 1'b0;
    exu_flush_pc = '0;
    exu_halt_req = 1'b0;

    //            rdy fl fpc       hlt req addr      ov opc       ack
    vecs[0]  = mk(1, 0, 32'h0,   0,  1, 32'h00,  0, 32'h00, 0);
    vecs[1]  = mk(1, 0, 32'h0,   0,  1, 32'h04,  0, 32'h00, 0);
    vecs[2]  = mk(1, 0, 32'h0,   0,  1, 32'h08,  1, 32'h00, 0);
    vecs[3]  = mk(1, 0, 32'h0,   0,  1, 32'h0C,  1, 32'h04, 0);
    vecs[4]  = mk(0, 0, 32'h0,   0,  0, 32'h00,  1, 32'h08, 0);
    vecs[5]  = mk(0, 0, 32'h0,   0,  0, 32'h00,  1, 32'h08, 0);
    vecs[6]  = mk(0, 0, 32'h0,   0,  0, 32'h00,  1, 32'h08, 0);
    vecs[7]  = mk(0, 0, 32'h0,   0,  0, 32'h00,  1, 32'h08, 0);
    vecs[8]  = mk(0, 0, 32'h0,   0,  0, 32'h00,  1, 32'h08, 0);
    vecs[9]  = mk(1, 0, 32'h0,   0,  1, 32'h10,  1, 32'h08, 0);
    vecs[10] = mk(1, 0, 32'h0,   0,  1, 32'h14,  1, 32'h0C, 0);
    vecs[11] = mk(1, 0, 32'h0,   0,  1, 32'h18,  1, 32'h10, 0);
    vecs[12] = mk(1, 0, 32'h0,   0,  1, 32'h1C,  1, 32'h14, 0);
    vecs[13] = mk(1, 1, 32'h40,  0,  0, 32'h00,  1, 32'h18, 0);
    vecs[14] = mk(1, 0, 32'h0,   0,  1, 32'h40,  0, 32'h00, 0);
    vecs[15] = mk(1, 0, 32'h0,   0,  1, 32'h44,  0, 32'h00, 0);
    vecs[16] = mk(1, 0, 32'h0,   0,  1, 32'h48,  1, 32'h40, 0);
    vecs[17] = mk(1, 0, 32'h0,   1,  0, 32'h00,  1, 32'h44, 0);
    vecs[18] = mk(0, 0, 32'h0,   1,  0, 32'h00,  1, 32'h48, 1);
    vecs[19] = mk(1, 0, 32'h0,   1,  0, 32'h00,  1, 32'h48, 1);
    vecs[20] = mk(1, 0, 32'h0,   0,  0, 32'h00,  0, 32'h00, 1);
    vecs[21] = mk(1, 0, 32'h0,   0,  1, 32'h4C,  0, 32'h00, 0);
    vecs[22] = mk(1, 0, 32'h0,   0,  1, 32'h50,  0, 32'h00, 0);
    vecs[23] = mk(1, 0, 32'h0,   0,  1, 32'h54,  1, 32'h4C, 0);
    vecs[24] = mk(1, 1, 32'h100, 1,  0, 32'h00,  1, 32'h50, 0);
    vecs[25] = mk(1, 0, 32'h0,   1,  0, 32'h00,  0, 32'h00, 0);
    vecs[26] = mk(1, 0, 32'h0,   1,  0, 32'h00,  0, 32'h00, 1);
    vecs[27] = mk(1, 0, 32'h0,   0,  0, 32'h00,  0, 32'h00, 1);
    vecs[28] = mk(1, 0, 32'h0,   0,  1, 32'h100, 0, 32'h00, 0);
    vecs[29] = mk(1, 0, 32'h0,   0,  1, 32'h104, 0, 32'h00, 0);
    vecs[30] = mk(1, 0, 32'h0,   0,  1, 32'h108, 1, 32'h100, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rdy, vecs[i].fl, vecs[i].fpc, vecs[i].hlt);
      chk($sformatf("v%0d_req_en", i), 32'(ifu_req_en), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("v%0d_req_addr", i), 32'(ifu_req_addr), vecs[i].addr);
      chk($sformatf("v%0d_o_valid", i), 32'(ifu_o_valid), 32'(vecs[i].ov));
      if (vecs[i].ov) begin
        chk($sformatf("v%0d_o_pc", i), 32'(ifu_o_pc), vecs[i].opc);
        chk($sformatf("v%0d_o_ir", i), 32'(ifu_o_ir), word(vecs[i].opc));
        chk($sformatf("v%0d_o_taken", i), 32'(ifu_o_prdt_taken), 32'd0);
      end
      chk($sformatf("v%0d_halt_ack", i), 32'(ifu_halt_ack), 32'(vecs[i].ack));
    end

    // Reset mid-stream; the response returning in the first post-reset cycle must be dropped.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals();
    drive(1, 0, 32'h0, 0);
    chk("mrst_req0", 32'(ifu_req_en), 32'd1);
    chk("mrst_addr0", 32'(ifu_req_addr), 32'h0);
    chk("mrst_ov0", 32'(ifu_o_valid), 32'd0);
    drive(1, 0, 32'h0, 0);
    chk("mrst_addr1", 32'(ifu_req_addr), 32'h4);
    chk("mrst_ov1", 32'(ifu_o_valid), 32'd0);
    drive(1, 0, 32'h0, 0);
    chk("mrst_addr2", 32'(ifu_req_addr), 32'h8);
    chk("mrst_ov2", 32'(ifu_o_valid), 32'd1);
    chk("mrst_opc2", 32'(ifu_o_pc), 32'h0);
    chk("mrst_ir2", 32'(ifu_o_ir), word(32'h0));

    // Branch at 0x20: backward (imm -8) then forward (imm +8).
    for (int k = 0; k < 2; k++) begin
      br_word = (k == 0) ? 32'hFE000CE3 : 32'h00000463;
`ifdef QPU_IFU_STATIC_BPU_EN
      exp_taken = (k == 0);
      exp_next  = (k == 0) ? 32'h18 : 32'h24;
      exp_after = (k == 0) ? 32'h1C : 32'h28;
`else
      exp_taken = 1'b0;
      exp_next  = 32'h24;
      exp_after = 32'h28;
`endif
      drive(1, 1, 32'h20, 0);
      chk($sformatf("br%0d_flush_req", k), 32'(ifu_req_en), 32'd0);
      drive(1, 0, 32'h0, 0);
      chk($sformatf("br%0d_req_addr0", k), 32'(ifu_req_addr), 32'h20);
      chk($sformatf("br%0d_ov0", k), 32'(ifu_o_valid), 32'd0);
      drive(1, 0, 32'h0, 0);
      chk($sformatf("br%0d_req_en1", k), 32'(ifu_req_en), 32'd1);
      chk($sformatf("br%0d_req_addr1", k), 32'(ifu_req_addr), exp_next);
      drive(1, 0, 32'h0, 0);
      chk($sformatf("br%0d_ov2", k), 32'(ifu_o_valid), 32'd1);
      chk($sformatf("br%0d_opc2", k), 32'(ifu_o_pc), 32'h20);
      chk($sformatf("br%0d_ir2", k), 32'(ifu_o_ir), br_word);
      chk($sformatf("br%0d_taken2", k), 32'(ifu_o_prdt_taken), 32'(exp_taken));
      chk($sformatf("br%0d_req_addr2", k), 32'(ifu_req_addr), exp_after);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpu_ifu_ifetch.md
QPU_IFU_IFETCH -- requirements
Module: QPU_ifu_ifetch

Interface
REQ-001 SHALL have parameter: RESET_PC, default `QPU_PC_SIZE'h0, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: ifu_req_en  output  1  instruction-memory read request this cycle.
REQ-005 SHALL have port: ifu_req_addr  output  `QPU_PC_SIZE  read address.
REQ-006 SHALL have port: ifu_rsp_instr  input  `QPU_INSTR_SIZE  read data, valid exactly 1 cycle after ifu_req_en.
REQ-007 SHALL have port: ifu_o_valid  output  1  IR holds an instruction for the decoder.
REQ-008 SHALL have port: exu_i_ready  input  1  decoder/EXU accepts IR; transfer when valid && ready.
REQ-009 SHALL have ports: ifu_o_ir  output  `QPU_INSTR_SIZE (drives decoder i_instr); ifu_o_pc  output  `QPU_PC_SIZE (i_pc); ifu_o_prdt_taken  output  1 (i_prdt_taken).
REQ-010 SHALL have ports: exu_flush_req  input  1  redirect fetch; exu_flush_pc  input  `QPU_PC_SIZE  redirect target.
REQ-011 SHALL have ports: exu_halt_req  input  1  level, stop fetching (WFI); ifu_halt_ack  output  1  fetch fully quiesced.

Function
REQ-012 SHALL hold fetched instructions in IR plus one skid entry; each entry stores instr, pc, prdt_taken; delivery strictly in fetch order.
REQ-013 SHALL track outstanding = 1 in the cycle after ifu_req_en, else 0; at most one outstanding read.
REQ-014 SHALL assert ifu_req_en only in FETCH, without flush or halt, when ir_valid + skid_valid + outstanding - (ifu_o_valid && exu_i_ready) < 2; sustains 1 instruction/cycle under constant ready.
REQ-015 SHALL load an arriving response into IR if IR empty-or-handed-off this cycle and skid empty, else into skid; skid moves to IR when IR frees.
REQ-016 SHALL keep ifu_o_ir/pc/prdt_taken stable while ifu_o_valid && !exu_i_ready.
REQ-017 SHALL maintain next-fetch PC; on issue, next PC = issued address + 4 (wraps modulo 2^`QPU_PC_SIZE).
REQ-018 SHALL predecode every arriving response: branch when instr[6:0] == 7'b1100011; imm = sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-019 SHALL implement states IDLE (one cycle after reset, no request), FETCH, HALT; IDLE -> FETCH unconditionally.
REQ-020 SHALL on exu_flush_req (any state, highest priority): clear IR and skid valid, discard the outstanding response, set next PC = exu_flush_pc, go to FETCH; first request for exu_flush_pc issues the following cycle; any handshake in the flush cycle is ignored.
REQ-021 SHALL on exu_halt_req in FETCH stop new requests; enter HALT once outstanding = 0; IR/skid contents remain deliverable.
REQ-022 SHALL assert ifu_halt_ack only in HALT; HALT -> FETCH when exu_halt_req deasserts, resuming at next PC.
REQ-023 SHALL give flush priority over halt when both asserted; flush with halt held still lands in HALT afterward via REQ-021.

Reset
REQ-024 SHALL on rst: state = IDLE, next PC = RESET_PC, IR/skid/outstanding cleared, ifu_o_valid = 0, ifu_req_en = 0, ifu_halt_ack = 0, ifu_o_ir = 0, ifu_o_pc = 0, ifu_o_prdt_taken = 0.
REQ-025 SHALL on rst mid-fetch discard the response arriving the cycle after reset.

Configuration
REQ-026 SHALL, with QPU_IFU_STATIC_BPU_EN defined, predict a predecoded branch with imm[`QPU_XLEN-1] = 1 as taken: entry prdt_taken = 1; next PC = branch pc + imm; a request issued in the response cycle uses that target combinationally.
REQ-027 SHALL, without QPU_IFU_STATIC_BPU_EN, tie prdt_taken to 0 and fetch sequentially only; predecode logic absent.

Verification
REQ-028 SHALL verify: reset with RESET_PC = 0, ready = 1 -> req addrs 0,4,8,... one per cycle from cycle 2; IR pc follows 1 cycle behind each request.
REQ-029 SHALL verify: ready low 5 cycles with IR valid -> at most 2 buffered, ifu_req_en low, outputs stable; release -> ordered delivery, no loss or duplication.
REQ-030 SHALL verify: flush with exu_flush_pc = 0x40 while outstanding -> in-flight instruction dropped, ifu_o_valid low next cycle, next request addr 0x40.
REQ-031 SHALL verify (macro on): BEQ at pc 0x20 with imm = -8 -> prdt_taken = 1, next request 0x18; imm = +8 -> prdt_taken = 0, next 0x24; macro off -> always 0, next 0x24.
REQ-032 SHALL verify: halt req while outstanding -> ack one cycle after response; halt release -> fetch resumes at stored next PC.
REQ-033 SHALL verify: simultaneous flush and halt -> flush applied, then HALT with ack; rst asserted mid-stream -> REQ-024 values next cycle.
